// File: rtl/rv32_pkg.sv
// Shared widths and write-back source encoding for the integer register file datapath.
package rv32_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LD
  } wb_src_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Small FIFO buffering load results ({rd,data}) that lose write-port arbitration.
module wb_load_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr, rptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rf_writeback_unit.sv
// Single writer of the regfile write port: ALU/load arbitration, pending-load scoreboard
// and forwarding of the write in flight.
module rf_writeback_unit
  import rv32_pkg::*;
#(
  parameter int XLEN     = rv32_pkg::XLEN,
  parameter int REG_AW   = rv32_pkg::REG_AW,
  parameter int LD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_issue_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rs1_fwd_valid,
  output logic              rs2_fwd_valid,
  output logic [XLEN-1:0]   rs1_fwd_data,
  output logic [XLEN-1:0]   rs2_fwd_data,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [NUM_REGS-1:0] busy_vec
);
  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [REG_AW+XLEN-1:0]   fifo_head;
  logic                     ld_acc, bypass_p0, vld_p0;
  wb_src_t                  src_p0;
  logic [REG_AW-1:0]        rd_p0;
  logic [XLEN-1:0]          data_p0;
  logic [NUM_REGS-1:0]      set_mask, clr_mask, busy_nxt;
  logic                     vld_p1;
  logic [REG_AW-1:0]        rd_p1;
  logic [XLEN-1:0]          data_p1;
  logic [NUM_REGS-1:0]      busy_p1;

  wb_load_fifo #(.DW(REG_AW+XLEN), .DEPTH(LD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({ld_rd, ld_data}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ld_ready = !fifo_full;
  assign ld_acc   = ld_valid && ld_ready;

  // Stage p0: pick the write-port winner (ALU, buffered load, bypassed load)
  always_comb begin
    src_p0    = WB_NONE;
    rd_p0     = '0;
    data_p0   = '0;
    fifo_pop  = 1'b0;
    bypass_p0 = 1'b0;
    if (alu_valid) begin
      src_p0  = WB_ALU;
      rd_p0   = alu_rd;
      data_p0 = alu_data;
    end else if (!fifo_empty) begin
      src_p0           = WB_LD;
      {rd_p0, data_p0} = fifo_head;
      fifo_pop         = 1'b1;
    end else if (ld_acc) begin
      src_p0    = WB_LD;
      rd_p0     = ld_rd;
      data_p0   = ld_data;
      bypass_p0 = 1'b1;
    end
  end

  assign fifo_push = ld_acc && !bypass_p0;
  assign vld_p0    = (src_p0 != WB_NONE) && (rd_p0 != '0);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (ld_issue)          set_mask[ld_issue_rd] = 1'b1;
    if (src_p0 == WB_LD)   clr_mask[rd_p0]       = 1'b1;
    busy_nxt    = (busy_p1 & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  // Stage p1: registered regfile write and scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
      busy_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      busy_p1 <= busy_nxt;
      if (vld_p0) begin
        rd_p1   <= rd_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign wb_we    = vld_p1;
  assign wb_rd    = rd_p1;
  assign wb_data  = data_p1;
  assign busy_vec = busy_p1;

  assign rs1_busy      = (rs1 != '0) && busy_p1[rs1];
  assign rs2_busy      = (rs2 != '0) && busy_p1[rs2];
  assign rs1_fwd_valid = vld_p1 && (rd_p1 == rs1) && (rs1 != '0);
  assign rs2_fwd_valid = vld_p1 && (rd_p1 == rs2) && (rs2 != '0);
  assign rs1_fwd_data  = data_p1;
  assign rs2_fwd_data  = data_p1;
endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit: arbitration, FIFO ordering, scoreboard, forwarding, reset.
module tb_rf_writeback_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;

  int n_cmp = 0;
  int n_err = 0;

  rf_writeback_unit #(.XLEN(32), .REG_AW(5), .LD_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_issue      (ld_issue),
    .ld_issue_rd   (ld_issue_rd),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_rd         (ld_rd),
    .ld_data       (ld_data),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_data  (rs2_fwd_data),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .busy_vec      (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we"}, 64'(wb_we), 64'(we));
    chk({tag, ".rd"}, 64'(wb_rd), 64'(rd));
    chk({tag, ".data"}, 64'(wb_data), 64'(d));
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    rs1 = '0; rs2 = '0;
    step(); step();
    chk_wb("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.busy_vec", 64'(busy_vec), 64'h0);
    rst_n = 1'b1;
    step();
    chk("post_reset.ld_ready", 64'(ld_ready), 64'h1);

    // ALU write and forwarding
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    alu_valid = 1'b0;
    chk_wb("alu5", 1'b1, 5'd5, 32'h1234);
    rs1 = 5'd5; rs2 = 5'd0;
    #1;
    chk("alu5.rs1_fwd_valid", 64'(rs1_fwd_valid), 64'h1);
    chk("alu5.rs1_fwd_data", 64'(rs1_fwd_data), 64'h1234);
    chk("alu5.rs2_fwd_valid", 64'(rs2_fwd_valid), 64'h0);
    step();
    chk_wb("idle_hold", 1'b0, 5'd5, 32'h1234);
    chk("idle.rs1_fwd_valid", 64'(rs1_fwd_valid), 64'h0);

    // Load issue sets busy; bypassed load write clears it
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    rs2 = 5'd7;
    #1;
    chk("ld7.rs2_busy", 64'(rs2_busy), 64'h1);
    chk("ld7.busy_vec", 64'(busy_vec), 64'h80);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEADBEEF;
    #1;
    chk("ld7.ld_ready", 64'(ld_ready), 64'h1);
    step();
    ld_valid = 1'b0;
    chk_wb("ld7.bypass", 1'b1, 5'd7, 32'hDEADBEEF);
    chk("ld7.busy_clr", 64'(busy_vec), 64'h0);
    chk("ld7.rs2_busy_clr", 64'(rs2_busy), 64'h0);
    rs1 = 5'd0; rs2 = 5'd0;

    // ALU starves loads; buffered loads drain in order
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h11;
    #1;
    chk("starve0.ld_ready", 64'(ld_ready), 64'h1);
    step();
    chk_wb("starve0", 1'b1, 5'd10, 32'hA0);
    alu_rd = 5'd11; alu_data = 32'hA1;
    ld_rd = 5'd2; ld_data = 32'h22;
    #1;
    chk("starve1.ld_ready", 64'(ld_ready), 64'h1);
    step();
    chk_wb("starve1", 1'b1, 5'd11, 32'hA1);
    alu_rd = 5'd12; alu_data = 32'hA2;
    ld_rd = 5'd3; ld_data = 32'h33;
    #1;
    chk("starve2.ld_ready", 64'(ld_ready), 64'h0);
    step();
    chk_wb("starve2", 1'b1, 5'd12, 32'hA2);
    alu_rd = 5'd13; alu_data = 32'hA3;
    #1;
    chk("starve3.ld_ready", 64'(ld_ready), 64'h0);
    step();
    chk_wb("starve3", 1'b1, 5'd13, 32'hA3);
    alu_valid = 1'b0;
    #1;
    chk("drain0.ld_ready", 64'(ld_ready), 64'h0);
    step();
    chk_wb("drain.rd1", 1'b1, 5'd1, 32'h11);
    chk("drain1.ld_ready", 64'(ld_ready), 64'h1);
    step();
    ld_valid = 1'b0;
    chk_wb("drain.rd2", 1'b1, 5'd2, 32'h22);
    step();
    chk_wb("drain.rd3", 1'b1, 5'd3, 32'h33);
    step();
    chk_wb("drain.idle", 1'b0, 5'd3, 32'h33);

    // x0 never written, never marked busy
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    step();
    alu_valid = 1'b0; ld_issue = 1'b0;
    chk("x0.wb_we", 64'(wb_we), 64'h0);
    chk("x0.busy_vec", 64'(busy_vec), 64'h0);

    // Set beats clear on the same register
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    chk("set9.busy_vec", 64'(busy_vec), 64'h200);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    step();
    ld_issue = 1'b0; ld_valid = 1'b0;
    chk_wb("set_wins", 1'b1, 5'd9, 32'h99);
    chk("set_wins.busy_vec", 64'(busy_vec), 64'h200);

    // Reset with two buffered loads
    ld_issue = 1'b1; ld_issue_rd = 5'd8;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hB0;
    ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h88;
    step();
    ld_issue = 1'b0;
    alu_rd = 5'd21; alu_data = 32'hB1;
    ld_rd = 5'd9; ld_data = 32'h9B;
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("prerst.busy_vec", 64'(busy_vec), 64'h300);
    chk("prerst.ld_ready", 64'(ld_ready), 64'h0);
    chk_wb("prerst", 1'b1, 5'd21, 32'hB1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_wb("midrst", 1'b0, 5'd0, 32'h0);
    chk("midrst.busy_vec", 64'(busy_vec), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst.ld_ready", 64'(ld_ready), 64'h1);
    for (int i = 0; i < 3; i++) begin
      chk("postrst.wb_we", 64'(wb_we), 64'h0);
      step();
    end
    chk("postrst.busy_vec", 64'(busy_vec), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_writeback_unit.md
Name: rf_writeback_unit

Overview:
- Write-side front end for the 32x32 integer register file. It is the single writer of the regfile's we/rd/indata port.
- Merges results from the single-cycle ALU path and the multi-cycle load unit, giving the ALU priority. Load results that lose arbitration are buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard and a one-cycle forward path for the value currently being written, so decode can stall or bypass correctly.

Parameters:
- XLEN, 32, data width
- REG_AW, 5, register address width
- LD_DEPTH, 2, load result buffer depth (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid this cycle (no backpressure)
- alu_rd  in  REG_AW  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
- ld_issue_rd  in  REG_AW  destination of the issued load
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid&&ld_ready
- ld_rd  in  REG_AW  load destination
- ld_data  in  XLEN  load data
- rs1, rs2  in  REG_AW  decode source addresses
- rs1_busy, rs2_busy  out  1  source has a pending load
- rs1_fwd_valid, rs2_fwd_valid  out  1  source matches the write in flight
- rs1_fwd_data, rs2_fwd_data  out  XLEN  forwarded value (wb_data)
- wb_we  out  1  regfile write enable (registered)
- wb_rd  out  REG_AW  regfile write address (registered)
- wb_data  out  XLEN  regfile write data (registered)
- busy_vec  out  32  scoreboard bits, bit0 always 0

Behaviour:
- Reset (async, rst_n=0):
  - wb_we=0, wb_rd=0, wb_data=0.
  - busy_vec=0.
  - FIFO emptied; ld_ready=1 one cycle after release.
  - Reset mid-operation discards buffered loads and in-flight writes.
- Arbitration, evaluated each cycle; winner is registered onto wb_* at the next edge (latency 1):
  1. alu_valid.
  2. FIFO head.
  3. Bypass: incoming accepted load when the FIFO is empty and alu_valid=0.
  4. None: wb_we=0; wb_rd and wb_data hold their previous values.
- FIFO: an accepted load that is not bypassed is pushed. Simultaneous push and pop when full is allowed.
- ld_ready = !full. This is combinational from FIFO count only, never from ld_valid.
- Order: loads are written in acceptance order. The ALU may overtake buffered loads.
- x0 rule: a winner with rd=0 is consumed (popped/accepted) but produces wb_we=0. wb_we=1 never occurs with wb_rd=0.
- Scoreboard:
  - Set: busy[ld_issue_rd] on ld_issue, unless ld_issue_rd=0.
  - Clear: busy[wb_rd] at the edge where a load-sourced write is registered.
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never touch busy.
- Busy outputs: rsN_busy = busy_vec[rsN]; 0 for rsN=0. Combinational from registered state.
- Forward outputs: rsN_fwd_valid = wb_we && wb_rd==rsN && rsN!=0; rsN_fwd_data=wb_data. This covers the regfile's clocked read seeing the old value in the write cycle.
- WAW: an ALU write to a busy register proceeds; busy stays set. Issue logic must stall on busy.
- Starvation: continuous alu_valid stalls the FIFO. ld_ready falls to 0 when full. No drop, no overflow.

Decomposition:
- Package rv32_pkg: XLEN, REG_AW, NUM_REGS=32, wb_src_t enum {WB_NONE, WB_ALU, WB_LD}.
- Sub-module wb_load_fifo: parameterised LD_DEPTH FIFO of {rd,data} with push, pop, full, empty and head outputs. Wrap-around uses pointers with an extra bit.
- Arbitration, scoreboard and forwarding stay in the top module.

Test Plan:
- Reset release, then alu_valid rd=5 data=0x1234 -> next cycle wb_we=1, wb_rd=5, wb_data=0x1234; rs1=5 gives rs1_fwd_valid=1, rs1_fwd_data=0x1234.
- ld_issue rd=7, then rs2=7 -> rs2_busy=1. Later ld_valid rd=7 data=0xDEADBEEF, FIFO empty, no ALU -> wb write next cycle and busy_vec[7] cleared at the same edge.
- alu_valid held high 4 cycles while offering 3 loads rd=1,2,3 -> first two accepted, ld_ready=0 on the third. After ALU stops, writes rd=1,2,3 occur in order on consecutive cycles.
- alu_valid rd=0 and ld_issue rd=0 -> wb_we stays 0, busy_vec stays 0.
- ld_issue rd=9 in the same cycle as a load writeback to rd=9 is registered -> busy_vec[9]=1 afterwards.
- rst_n asserted with 2 loads buffered and busy_vec=0x0000_0300 -> wb_we=0, busy_vec=0 immediately. No buffered load is written after release.
